// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and coordinate type
package vga_pkg;

  localparam int CLK_DIV_DEF  = 2;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster coordinate and sync bundle
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_en;
  logic   vga_clk;
  coord_t x;
  coord_t y;
  logic   hsync;
  logic   vsync;
  logic   blank_n;
  logic   sync_n;
  logic   frame_start;

  modport master (
    output pix_en, vga_clk, x, y, hsync, vsync, blank_n, sync_n, frame_start
  );

  modport slave (
    input pix_en, vga_clk, x, y, hsync, vsync, blank_n, sync_n, frame_start
  );

endinterface

// File: rtl/pix_tick_gen.sv
// rtl/pix_tick_gen.sv - system-clock divider giving the pixel enable and DAC pixel clock
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic vga_clk
);

  localparam int HIGH_LEN = (CLK_DIV + 1) / 2;
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div;
  logic [1:0] div_nxt;
  logic       started;

  always_comb begin
    div_nxt = (div == DIV_LAST) ? 2'd0 : div + 2'd1;
  end

  // started keeps pix_en low on the first clock after reset even when CLK_DIV is 1
  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= 2'd0;
      started <= 1'b0;
      vga_clk <= 1'b0;
    end else begin
      div     <= div_nxt;
      started <= 1'b1;
      vga_clk <= (div_nxt < 2'(HIGH_LEN));
    end
  end

  assign pix_en = started & ~reset & (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with registered sync/blank decode
module vga_timing_gen import vga_pkg::*; #(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_ACTIVE + H_FP;
  localparam int HSE = HSS + H_SYNC;
  localparam int VSS = V_ACTIVE + V_FP;
  localparam int VSE = VSS + V_SYNC;

  generate
    if (HT > 1024 || VT > 1024) begin : g_bad_total
      $error("vga_timing_gen: line or frame total exceeds 10-bit counter");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be 1..4");
    end
  endgenerate

  logic   pix_en;
  logic   vga_clk;
  coord_t x, y, x_nxt, y_nxt;
  logic   line_end, frame_end;
  logic   hsync, vsync, blank_n, frame_start;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .pix_en  (pix_en),
    .vga_clk (vga_clk)
  );

  always_comb begin
    line_end  = (x == coord_t'(HT - 1));
    frame_end = line_end && (y == coord_t'(VT - 1));
    x_nxt     = x;
    y_nxt     = y;
    if (pix_en) begin
      if (line_end) begin
        x_nxt = '0;
        y_nxt = frame_end ? '0 : y + 10'd1;
      end else begin
        x_nxt = x + 10'd1;
      end
    end
  end

  // Decode from next-state coordinates so syncs land on the same edge as x/y
  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= !((x_nxt >= coord_t'(HSS)) && (x_nxt < coord_t'(HSE)));
      vsync       <= !((y_nxt >= coord_t'(VSS)) && (y_nxt < coord_t'(VSE)));
      blank_n     <= (x_nxt < coord_t'(H_ACTIVE)) && (y_nxt < coord_t'(V_ACTIVE));
      frame_start <= pix_en && frame_end;
    end
  end

  assign vif.pix_en      = pix_en;
  assign vif.vga_clk     = vga_clk;
  assign vif.x           = x;
  assign vif.y           = y;
  assign vif.hsync       = hsync;
  assign vif.vsync       = vsync;
  assign vif.blank_n     = blank_n;
  assign vif.sync_n      = 1'b0;
  assign vif.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - three timing generators against an arithmetic raster model
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  int   t;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  int   fs_last;
  bit   fs_valid;
  int   hs_cnt;
  bit   hs_valid;
  logic hs_prev;

  vga_timing_gen_if a_if ();
  vga_timing_gen_if b_if ();
  vga_timing_gen_if c_if ();

  vga_timing_gen u_a (
    .clk   (clk),
    .reset (rst),
    .vif   (a_if.master)
  );

  vga_timing_gen #(.CLK_DIV(1)) u_b (
    .clk   (clk),
    .reset (rst),
    .vif   (b_if.master)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_c (
    .clk   (clk),
    .reset (rst),
    .vif   (c_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  // pixel ticks consumed after t clocks out of reset
  function automatic int pix_count(input int tt, input int d);
    if (tt <= 0) return 0;
    if (d == 1) return tt - 1;
    return tt / d;
  endfunction

  task automatic check_dut(
    input string nm, input int d,
    input int ha, input int hfp, input int hsw, input int hbp,
    input int va, input int vfp, input int vsw, input int vbp,
    input logic pe, input logic vc, input logic [9:0] xo, input logic [9:0] yo,
    input logic hs, input logic vs, input logic bn, input logic sn, input logic fs
  );
    int ht, vt, p, pp, ex, ey;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p  = pix_count(t, d);
    pp = pix_count(t - 1, d);
    ex = p % ht;
    ey = (p / ht) % vt;
    check_eq({nm, ".x"}, int'(xo), ex);
    check_eq({nm, ".y"}, int'(yo), ey);
    check_eq({nm, ".pix_en"}, int'(pe), int'(!rst && t >= 1 && (t % d) == d - 1));
    check_eq({nm, ".vga_clk"}, int'(vc), int'(t >= 1 && (t % d) < (d + 1) / 2));
    check_eq({nm, ".hsync"}, int'(hs), int'(!(ex >= ha + hfp && ex < ha + hfp + hsw)));
    check_eq({nm, ".vsync"}, int'(vs), int'(!(ey >= va + vfp && ey < va + vfp + vsw)));
    check_eq({nm, ".blank_n"}, int'(bn), int'(ex < ha && ey < va));
    check_eq({nm, ".sync_n"}, int'(sn), 0);
    check_eq({nm, ".frame_start"}, int'(fs), int'(t >= 1 && p != pp && (p % (ht * vt)) == 0));
  endtask

  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    cyc++;
    if (r) t = 0;
    else   t++;
    @(negedge clk);
    check_dut("a", 2, 640, 16, 96, 48, 480, 10, 2, 33,
              a_if.pix_en, a_if.vga_clk, a_if.x, a_if.y, a_if.hsync, a_if.vsync,
              a_if.blank_n, a_if.sync_n, a_if.frame_start);
    check_dut("b", 1, 640, 16, 96, 48, 480, 10, 2, 33,
              b_if.pix_en, b_if.vga_clk, b_if.x, b_if.y, b_if.hsync, b_if.vsync,
              b_if.blank_n, b_if.sync_n, b_if.frame_start);
    check_dut("c", 2, 16, 4, 6, 5, 12, 2, 2, 3,
              c_if.pix_en, c_if.vga_clk, c_if.x, c_if.y, c_if.hsync, c_if.vsync,
              c_if.blank_n, c_if.sync_n, c_if.frame_start);
    if (r) begin
      fs_valid = 1'b0;
      hs_valid = 1'b0;
    end
    if (c_if.frame_start === 1'b1) begin
      if (fs_valid) check_eq("c.frame_period", cyc - fs_last, 31 * 19 * 2);
      fs_last  = cyc;
      fs_valid = 1'b1;
    end
    if (a_if.hsync === 1'b0) begin
      if (hs_prev === 1'b1) begin
        hs_cnt   = 0;
        hs_valid = !r;
      end
      hs_cnt++;
    end else if (hs_prev === 1'b0 && hs_valid) begin
      check_eq("a.hsync_low_clks", hs_cnt, 192);
      hs_valid = 1'b0;
    end
    hs_prev = a_if.hsync;
  endtask

  initial begin
    rst      = 1'b1;
    t        = 0;
    cyc      = 0;
    n_cmp    = 0;
    n_bad    = 0;
    fs_last  = 0;
    fs_valid = 1'b0;
    hs_cnt   = 0;
    hs_valid = 1'b0;
    hs_prev  = 1'b1;

    repeat (5) step(1'b1);
    repeat (5000) step(1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(100, 2500)) step(1'b0);
      repeat ($urandom_range(1, 3)) step(1'b1);
    end
    repeat (3000) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
